// File: rtl/lab61soc_poll_pkg.sv
// Shared types and sizing helpers for the lab61soc PIO poll master.
package lab61soc_poll_pkg;

  localparam int POLL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lab61soc_poll_timer.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module lab61soc_poll_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lab61soc_pio_poll_master.sv
// Avalon-MM read initiator that periodically polls one PIO register and
// reports the held value, a per-capture strobe and a change pulse.
//
// state | meaning
// IDLE  | interval counter running (while enable); no read outstanding
// REQ   | avm_read asserted, waiting for waitrequest low
// WAIT  | read accepted, counting down slave latency; exit edge captures data
module lab61soc_pio_poll_master
  import lab61soc_poll_pkg::*;
#(
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 32,
  parameter int READ_LATENCY  = 1,
  parameter int POLL_INTERVAL = 1000,
  parameter int TARGET_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]     value,
  output logic                  value_valid,
  output logic                  sample_strobe,
  output logic                  changed,
  output logic [POLL_CNT_W-1:0] poll_count
);

  localparam int IW = clog2(POLL_INTERVAL + 1);
  localparam int LW = clog2(READ_LATENCY + 1);
  localparam logic [IW-1:0] INT_RELOAD = IW'(POLL_INTERVAL - 1);
  localparam logic [LW-1:0] LAT_RELOAD = LW'(READ_LATENCY - 1);

  state_e state_q, state_d;

  logic                  accept;
  logic                  capture;
  logic                  int_zero;
  logic                  lat_zero;

  logic [DATA_W-1:0]     value_q, value_d;
  logic                  valid_q, valid_d;
  logic                  strobe_q, strobe_d;
  logic                  changed_q, changed_d;
  logic [POLL_CNT_W-1:0] count_q, count_d;

  assign accept  = (state_q == REQ) && !avm_waitrequest;
  assign capture = (state_q == WAIT) && lat_zero;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable && int_zero) state_d = REQ;
      REQ:     if (!avm_waitrequest) state_d = WAIT;
      WAIT:    if (lat_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Interval counter freezes whenever enable is low, so re-enabling resumes it.
  lab61soc_poll_timer #(.W(IW)) u_interval (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .load_i     (capture),
    .load_val_i (INT_RELOAD),
    .dec_i      ((state_q == IDLE) && enable),
    .zero_o     (int_zero)
  );

  lab61soc_poll_timer #(.W(LW)) u_latency (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .load_i     (accept),
    .load_val_i (LAT_RELOAD),
    .dec_i      (state_q == WAIT),
    .zero_o     (lat_zero)
  );

  always_comb begin
    value_d   = value_q;
    valid_d   = valid_q;
    count_d   = count_q;
    strobe_d  = capture;
    changed_d = capture && valid_q && (avm_readdata != value_q);
    if (capture) begin
      value_d = avm_readdata;
      valid_d = 1'b1;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q   <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      changed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      value_q   <= value_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      changed_q <= changed_d;
      count_q   <= count_d;
    end
  end

  assign avm_address   = ADDR_W'(TARGET_ADDR);
  assign avm_read      = (state_q == REQ);
  assign value         = value_q;
  assign value_valid   = valid_q;
  assign sample_strobe = strobe_q;
  assign changed       = changed_q;
  assign poll_count    = count_q;

endmodule

// File: tb/tb_lab61soc_pio_poll_master.sv
// Directed bench: cycle table for basic polling, then hand sequences for
// stalls, enable freeze, async reset and latency-3 counter wrap.
module tb_lab61soc_pio_poll_master;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic clk;
  logic rst1_n, en1, wr1, read1, vv1, st1, ch1;
  logic [1:0]  addr1;
  logic [31:0] rd1, value1;
  logic [15:0] cnt1;
  logic rst3_n, en3, wr3, read3, vv3, st3, ch3;
  logic [1:0]  addr3;
  logic [31:0] rd3, value3;
  logic [15:0] cnt3;

  int errors = 0;
  int checks = 0;

  lab61soc_pio_poll_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1), .POLL_INTERVAL(4), .TARGET_ADDR(0)
  ) dut1 (
    .clk(clk), .reset_n(rst1_n), .enable(en1), .avm_address(addr1), .avm_read(read1),
    .avm_waitrequest(wr1), .avm_readdata(rd1), .value(value1), .value_valid(vv1),
    .sample_strobe(st1), .changed(ch1), .poll_count(cnt1)
  );

  lab61soc_pio_poll_master #(
    .ADDR_W(2), .DATA_W(32), .READ_LATENCY(3), .POLL_INTERVAL(4), .TARGET_ADDR(0)
  ) dut3 (
    .clk(clk), .reset_n(rst3_n), .enable(en3), .avm_address(addr3), .avm_read(read3),
    .avm_waitrequest(wr3), .avm_readdata(rd3), .value(value3), .value_valid(vv3),
    .sample_strobe(st3), .changed(ch3), .poll_count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        rd_exp;
    logic [31:0] val;
    logic        vv;
    logic        st;
    logic        ch;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic [31:0] rd, logic r, logic [31:0] v, logic vv,
                              logic st, logic ch, logic [15:0] c);
    vec_t t;
    t.rd = rd; t.rd_exp = r; t.val = v; t.vv = vv; t.st = st; t.ch = ch; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_read1(input string nm);
    int n;
    n = 0;
    while (read1 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 32'(read1), 32'd1);
  endtask

  task automatic chk1(input string nm, input logic r, input logic [31:0] v, input logic vv,
                      input logic st, input logic ch, input logic [15:0] c);
    chk({nm, "_read"},   32'(read1),  32'(r));
    chk({nm, "_value"},  value1,      v);
    chk({nm, "_valid"},  32'(vv1),    32'(vv));
    chk({nm, "_strobe"}, 32'(st1),    32'(st));
    chk({nm, "_changed"},32'(ch1),    32'(ch));
    chk({nm, "_count"},  32'(cnt1),   32'(c));
  endtask

  task automatic chk3(input string nm, input logic r, input logic [31:0] v, input logic vv,
                      input logic st, input logic ch, input logic [15:0] c);
    chk({nm, "_read"},   32'(read3),  32'(r));
    chk({nm, "_value"},  value3,      v);
    chk({nm, "_valid"},  32'(vv3),    32'(vv));
    chk({nm, "_strobe"}, 32'(st3),    32'(st));
    chk({nm, "_changed"},32'(ch3),    32'(ch));
    chk({nm, "_count"},  32'(cnt3),   32'(c));
  endtask

  initial begin
    rst1_n = 1'b0; en1 = 1'b0; wr1 = 1'b0; rd1 = JUNK;
    rst3_n = 1'b0; en3 = 1'b0; wr3 = 1'b0; rd3 = JUNK;

    tbl[0]  = mk(JUNK,  1, 32'h0, 0, 0, 0, 16'd0);
    tbl[1]  = mk(JUNK,  0, 32'h0, 0, 0, 0, 16'd0);
    tbl[2]  = mk(32'h1, 0, 32'h1, 1, 1, 0, 16'd1);
    tbl[3]  = mk(JUNK,  0, 32'h1, 1, 0, 0, 16'd1);
    tbl[4]  = mk(JUNK,  0, 32'h1, 1, 0, 0, 16'd1);
    tbl[5]  = mk(JUNK,  0, 32'h1, 1, 0, 0, 16'd1);
    tbl[6]  = mk(JUNK,  1, 32'h1, 1, 0, 0, 16'd1);
    tbl[7]  = mk(JUNK,  0, 32'h1, 1, 0, 0, 16'd1);
    tbl[8]  = mk(32'h0, 0, 32'h0, 1, 1, 1, 16'd2);
    tbl[9]  = mk(JUNK,  0, 32'h0, 1, 0, 0, 16'd2);
    tbl[10] = mk(JUNK,  0, 32'h0, 1, 0, 0, 16'd2);
    tbl[11] = mk(JUNK,  0, 32'h0, 1, 0, 0, 16'd2);
    tbl[12] = mk(JUNK,  1, 32'h0, 1, 0, 0, 16'd2);
    tbl[13] = mk(JUNK,  0, 32'h0, 1, 0, 0, 16'd2);
    tbl[14] = mk(32'h0, 0, 32'h0, 1, 1, 0, 16'd3);
    tbl[15] = mk(JUNK,  0, 32'h0, 1, 0, 0, 16'd3);

    tick(); tick();
    chk1("reset1", 0, 32'h0, 0, 0, 0, 16'd0);
    chk3("reset3", 0, 32'h0, 0, 0, 0, 16'd0);
    chk("reset1_addr", 32'(addr1), 32'd0);
    rst1_n = 1'b1; rst3_n = 1'b1;
    tick();
    chk("idle_no_read", 32'(read1), 32'd0);

    // Basic polling, change detect and steady data.
    en1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd1 = tbl[i].rd;
      tick();
      chk1($sformatf("vec%0d", i), tbl[i].rd_exp, tbl[i].val, tbl[i].vv,
           tbl[i].st, tbl[i].ch, tbl[i].cnt);
      chk($sformatf("vec%0d_addr", i), 32'(addr1), 32'd0);
    end

    // Three stall cycles at the request.
    rd1 = JUNK; wr1 = 1'b1;
    wait_read1("stall_read_seen");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_read", i), 32'(read1), 32'd1);
      chk($sformatf("stall%0d_addr", i), 32'(addr1), 32'd0);
    end
    wr1 = 1'b0;
    tick();
    chk1("stall_accept", 0, 32'h0, 1, 0, 0, 16'd3);
    rd1 = 32'hA5A5_0003;
    tick();
    chk1("stall_capture", 0, 32'hA5A5_0003, 1, 1, 1, 16'd4);
    rd1 = JUNK;
    tick();
    chk1("stall_after", 0, 32'hA5A5_0003, 1, 0, 0, 16'd4);

    // Enable dropped as read rises: read still completes, then counter freezes.
    wr1 = 1'b1;
    wait_read1("endrop_read_seen");
    en1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("endrop_hold%0d", i), 32'(read1), 32'd1);
    end
    wr1 = 1'b0;
    tick();
    chk("endrop_accept", 32'(read1), 32'd0);
    rd1 = 32'h1234_5678;
    tick();
    chk1("endrop_capture", 0, 32'h1234_5678, 1, 1, 1, 16'd5);
    rd1 = JUNK;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("frozen%0d_read", i), 32'(read1), 32'd0);
    end
    en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("resume%0d_read", i), 32'(read1), 32'd0);
    end
    tick();
    chk("resume_read_rise", 32'(read1), 32'd1);

    // Async reset while waiting for read data.
    tick();
    chk("rst_accept", 32'(read1), 32'd0);
    #3;
    rst1_n = 1'b0;
    #1;
    chk1("rst_async", 0, 32'h0, 0, 0, 0, 16'd0);
    en1 = 1'b0;
    tick();
    chk1("rst_held", 0, 32'h0, 0, 0, 0, 16'd0);
    rst1_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("rst_post%0d", i), 0, 32'h0, 0, 0, 0, 16'd0);
    end
    en1 = 1'b1;
    tick();
    chk("rst_first_read", 32'(read1), 32'd1);
    tick();
    chk("rst_first_accept", 32'(read1), 32'd0);
    rd1 = 32'h77;
    tick();
    chk1("rst_first_capture", 0, 32'h77, 1, 1, 0, 16'd1);
    en1 = 1'b0;

    // Latency 3 and poll_count wrap (counter preset near the top).
    force dut3.count_q = 16'hFFFE;
    #1;
    release dut3.count_q;
    chk("preset_count", 32'(cnt3), 32'h0000_FFFE);
    en3 = 1'b1; wr3 = 1'b0; rd3 = JUNK;
    tick();
    chk("l3_read_rise", 32'(read3), 32'd1);
    tick();
    chk("l3_accept", 32'(read3), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("l3_wait%0d_strobe", i), 32'(st3), 32'd0);
    end
    rd3 = 32'hCAFE_0001;
    tick();
    chk3("l3_capture1", 0, 32'hCAFE_0001, 1, 1, 0, 16'hFFFF);
    rd3 = JUNK;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3_gap%0d_read", i), 32'(read3), 32'd0);
    end
    tick();
    chk("l3_read_rise2", 32'(read3), 32'd1);
    tick();
    chk("l3_accept2", 32'(read3), 32'd0);
    tick(); tick();
    chk("l3_wait_strobe2", 32'(st3), 32'd0);
    rd3 = 32'hCAFE_0002;
    tick();
    chk3("l3_capture2_wrap", 0, 32'hCAFE_0002, 1, 1, 1, 16'h0000);
    rd3 = JUNK;
    tick();
    chk3("l3_after", 0, 32'hCAFE_0002, 1, 0, 0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
